// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for the round-robin register-load arbiter:
// FSM state encoding and default sizing constants.
package reg_load_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_load_arbiter_if.sv
// Requester-side bus of the register-load arbiter: level requests with packed
// write data in, shared register value plus grant/ack/busy status out.
interface reg_load_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [WIDTH-1:0]      A;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;

    modport master (
        output req, din,
        input  A, gnt, ack, busy
    );

    modport slave (
        input  req, din,
        output A, gnt, ack, busy
    );

endinterface

// File: rtl/reg_load_arbiter_par_load_reg.sv
// Parallel-load register with synchronous clear; holds its value whenever
// load is low.
module par_load_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] A
);

    always_ff @(posedge clk) begin
        if (rst) begin
            A <= '0;
        end else if (load) begin
            A <= I;
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared register via an IDLE -> LOAD -> ACK sequence.
module reg_load_arbiter
    import reg_load_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    reg_load_arbiter_if.slave bus
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t state;
    state_t state_next;

    logic [IDXW-1:0]  last_winner;
    logic [IDXW-1:0]  winner;
    logic [IDXW-1:0]  sel;
    logic             sel_found;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] staging;
    logic [NREQ-1:0]  winner_oh;
    logic             load;
    logic [WIDTH-1:0] reg_value;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic             busy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = sel_found ? LOAD : IDLE;
            LOAD:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Search starts one past the previous winner and wraps modulo NREQ
    always_comb begin
        sel       = last_winner;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned cand;
            cand = (int'(last_winner) + 1 + i) % NREQ;
            if (!sel_found && bus.req[IDXW'(cand)]) begin
                sel       = IDXW'(cand);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDXW'(i) == sel) begin
                sel_data = bus.din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Winner and data are captured only on the grant edge, so later changes
    // on req/din cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner      <= '0;
            staging     <= '0;
            last_winner <= IDXW'(NREQ - 1);
        end else if (state == IDLE && sel_found) begin
            winner      <= sel;
            staging     <= sel_data;
            last_winner <= sel;
        end
    end

    always_comb begin
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
    end

    // Output decode from registered state only
    always_comb begin
        gnt  = '0;
        ack  = '0;
        load = 1'b0;
        busy = 1'b0;
        unique case (state)
            IDLE: begin
            end
            LOAD: begin
                gnt  = winner_oh;
                load = 1'b1;
                busy = 1'b1;
            end
            ACK: begin
                gnt  = winner_oh;
                ack  = winner_oh;
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    par_load_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .rst (rst),
        .clk (clk),
        .load(load),
        .I   (staging),
        .A   (reg_value)
    );

    assign bus.A    = reg_value;
    assign bus.gnt  = gnt;
    assign bus.ack  = ack;
    assign bus.busy = busy;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: expected loads are queued when
// requests are driven and checked against each ack pulse.
module tb_reg_load_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;

    typedef struct {
        int unsigned      idx;
        logic [WIDTH-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned cyc        = 0;
    int unsigned last_ack_cyc;
    exp_t        exp_q[$];

    reg_load_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    reg_load_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_load(input int unsigned idx, input logic [WIDTH-1:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string tag, input logic [WIDTH-1:0] a_exp);
        check({tag, "_A"},    32'(bus.A),    32'(a_exp));
        check({tag, "_gnt"},  32'(bus.gnt),  32'd0);
        check({tag, "_ack"},  32'(bus.ack),  32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Tick until an ack appears, then score it against the oldest expectation
    task automatic wait_ack(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.ack != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check({tag, "_ack_timeout"}, 32'(bus.ack), 32'hFFFF_FFFF);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected_ack"}, 32'(bus.ack), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_ack"},  32'(bus.ack),  32'd1 << e.idx);
            check({tag, "_gnt"},  32'(bus.gnt),  32'd1 << e.idx);
            check({tag, "_A"},    32'(bus.A),    32'(e.val));
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        end
    endtask

    initial begin
        bus.req = '0;
        bus.din = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_idle("reset", 4'h0);
        rst = 1'b0;

        // Single request, check every phase
        bus.req = 4'b0001;
        bus.din = {4'h0, 4'h0, 4'h0, 4'b1010};
        expect_load(0, 4'b1010);
        tick();
        check("single_load_gnt",  32'(bus.gnt),  32'b0001);
        check("single_load_ack",  32'(bus.ack),  32'd0);
        check("single_load_busy", 32'(bus.busy), 32'd1);
        check("single_load_A",    32'(bus.A),    32'd0);
        bus.req = '0;
        wait_ack("single");
        tick();
        check_idle("single_after", 4'b1010);

        // All requesting: rotation 0,1,2,3,0 at one load per 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.din = {4'd4, 4'd3, 4'd2, 4'd1};
        expect_load(0, 4'd1);
        expect_load(1, 4'd2);
        expect_load(2, 4'd3);
        expect_load(3, 4'd4);
        expect_load(0, 4'd1);
        for (int n = 0; n < 5; n++) begin
            wait_ack("rr");
            if (n > 0) check("rr_spacing", cyc - last_ack_cyc, 32'd3);
            last_ack_cyc = cyc;
        end
        bus.req = '0;
        tick();
        check("rr_idle_busy", 32'(bus.busy), 32'd0);

        // Requester changes req/din after grant; staged data must win
        bus.req = 4'b0100;
        bus.din = {4'h0, 4'b0110, 4'h0, 4'h0};
        expect_load(2, 4'b0110);
        tick();
        check("late_change_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = 4'b1111;
        bus.din = {4'hF, 4'hF, 4'hF, 4'hF};
        wait_ack("late_change");
        bus.req = '0;
        tick();
        check_idle("late_change_after", 4'b0110);

        // Reset during LOAD aborts the operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1000;
        bus.din = {4'hF, 4'h0, 4'h0, 4'h0};
        tick();
        check("abort_gnt", 32'(bus.gnt), 32'b1000);
        rst = 1'b1;
        tick();
        check_idle("abort_rst", 4'h0);
        rst = 1'b0;
        bus.req = '0;
        tick();
        check_idle("abort_after", 4'h0);
        bus.req = 4'b1011;
        bus.din = {4'hF, 4'h0, 4'h5, 4'h9};
        expect_load(0, 4'h9);
        wait_ack("abort_next");
        bus.req = '0;
        tick();

        // Quiet period: register holds
        for (int n = 0; n < 10; n++) begin
            tick();
            check_idle("quiet", 4'h9);
        end

        // req[2] held, req[0] dropped on its ack and re-asserted
        bus.req = 4'b0101;
        bus.din = {4'h0, 4'hC, 4'h0, 4'h3};
        expect_load(2, 4'hC);
        expect_load(0, 4'h3);
        expect_load(2, 4'hC);
        expect_load(0, 4'h3);
        for (int n = 0; n < 4; n++) begin
            wait_ack("fair");
            if (bus.ack[0]) begin
                bus.req[0] = 1'b0;
                tick();
                bus.req[0] = 1'b1;
            end
        end
        bus.req = '0;
        tick();
        tick();
        check("fair_queue_empty", 32'(exp_q.size()), 32'd0);
        check_idle("final", 4'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
